// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - 4-channel TDM receive demultiplexer with frame lock tracking
//
// Purpose: accepts one slot word per valid cycle, slot 0 marked by in_sof, and
// steers each word to its channel register while tracking frame alignment
// through a HUNT/LOCKED state machine.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   word present on in_data
//   in_data    slot word (DATA_W bits)
//   in_sof     marks in_data as slot 0 (qualified by in_valid)
//   ch_data    channel registers, channel k at [k*DATA_W +: DATA_W]
//   ch_valid   one-cycle per-channel update strobe
//   frame_done one-cycle pulse when slot 3 of a locked frame is accepted
//   slot       slot index expected for the next accepted word
//   locked     high while in LOCKED
//   sync_err   one-cycle pulse on an alignment violation
//
// Build option: TDM_FRAME_LATCH_EN - collect a frame in a shadow bank and
// publish all four channels together when slot 3 is accepted.

module tdm_demux_rx #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic [1:0]               slot,
  output logic                     locked,
  output logic                     sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                    state_q;
  logic [1:0]                slot_q;
  logic [NUM_CH*DATA_W-1:0]  ch_data_q;
  logic [NUM_CH-1:0]         ch_valid_q;
  logic                      frame_done_q;
  logic                      sync_err_q;

`ifdef TDM_FRAME_LATCH_EN
  // Slots 1..2 are always rewritten after any slot-0 word before slot 3 can
  // publish, so stale shadow contents after an error never reach ch_data.
  logic [DATA_W-1:0]         shadow_q [NUM_CH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef TDM_FRAME_LATCH_EN
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
`endif
    end else begin
      // Strobes default low so every pulse is exactly one cycle wide.
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (in_valid) begin
        if (in_sof && (state_q == HUNT || slot_q == 2'd0 || state_q == LOCKED)) begin
          // Any SOF (first lock, normal start or early resync) restarts at slot 0.
          sync_err_q <= (state_q == LOCKED) && (slot_q != 2'd0);
          state_q    <= LOCKED;
          slot_q     <= 2'd1;
`ifdef TDM_FRAME_LATCH_EN
          shadow_q[0] <= in_data;
`else
          ch_data_q[DATA_W-1:0] <= in_data;
          ch_valid_q            <= NUM_CH'(1);
`endif
        end else if (state_q == LOCKED) begin
          if (slot_q == 2'd0) begin
            // Expected SOF did not arrive: drop the word and lose lock.
            sync_err_q <= 1'b1;
            state_q    <= HUNT;
          end else begin
            slot_q       <= slot_q + 2'd1;
            frame_done_q <= (slot_q == 2'd3);
`ifdef TDM_FRAME_LATCH_EN
            shadow_q[slot_q] <= in_data;
            if (slot_q == 2'd3) begin
              ch_data_q  <= {in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
              ch_valid_q <= '1;
            end
`else
            ch_data_q[int'(slot_q)*DATA_W +: DATA_W] <= in_data;
            ch_valid_q <= NUM_CH'(1) << slot_q;
`endif
          end
        end
        // HUNT without SOF: word is dropped silently.
      end
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign slot       = slot_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - self-checking bench for tdm_demux_rx
module tb_tdm_demux_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic [1:0]  slot;
  logic        locked;
  logic        sync_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: lock flag, expected next slot, channel contents and the
  // words collected so far in the current frame.
  bit         m_locked = 0;
  int         m_slot = 0;
  logic [7:0] m_ch [4] = '{default: 8'h00};
  logic [7:0] frame [$];
  logic [3:0] e_valid;
  bit         e_fd, e_err;

  always #5 clk = ~clk;

  tdm_demux_rx #(.DATA_W(8), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input logic [7:0] d);
    e_valid = '0; e_fd = 0; e_err = 0;
    if (r) begin
      m_locked = 0; m_slot = 0; frame.delete();
      for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
    end else if (v) begin
      if (s) begin
        if (m_locked && m_slot != 0) e_err = 1;
        m_locked = 1; m_slot = 1;
        frame.delete(); frame.push_back(d);
`ifndef TDM_FRAME_LATCH_EN
        m_ch[0] = d; e_valid = 4'b0001;
`endif
      end else if (m_locked) begin
        if (m_slot == 0) begin
          e_err = 1; m_locked = 0; frame.delete();
        end else begin
          frame.push_back(d);
`ifndef TDM_FRAME_LATCH_EN
          m_ch[m_slot] = d; e_valid[m_slot] = 1'b1;
`endif
          if (m_slot == 3) begin
            e_fd = 1;
`ifdef TDM_FRAME_LATCH_EN
            for (int k = 0; k < 4; k++) m_ch[k] = frame[k];
            e_valid = 4'b1111;
`endif
          end
          m_slot = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ch_data",    ch_data,         {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
    chk("ch_valid",   32'(ch_valid),   32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("sync_err",   32'(sync_err),   32'(e_err));
    chk("slot",       32'(slot),       32'(m_slot));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("fd_err_excl", 32'(frame_done & sync_err), 32'd0);
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [7:0] d);
    @(negedge clk);
    rst = r; in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    #1;
    model_step(r, v, s, d);
    check_all();
  endtask

  initial begin
    bit r, v, s;
    // Reset then clean frame
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'hA0);
    step(0, 1, 0, 8'hB1);
    step(0, 1, 0, 8'hC2);
    step(0, 1, 0, 8'hD3);
    chk("clean_frame_data", ch_data, 32'hD3C2B1A0);
    chk("clean_frame_slot", 32'(slot), 32'd0);

    // Hunt discard
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 1, 8'h33);
`ifndef TDM_FRAME_LATCH_EN
    chk("hunt_ch0", 32'(ch_data[7:0]), 32'h33);
`endif
    chk("hunt_locked", 32'(locked), 32'd1);
    step(0, 1, 0, 8'h34);
    step(0, 1, 0, 8'h35);
    step(0, 1, 0, 8'h36);

    // Early SOF
    step(0, 1, 1, 8'h10);
    step(0, 1, 0, 8'h20);
    step(0, 1, 1, 8'h30);
    chk("early_sof_err", 32'(sync_err), 32'd1);
    chk("early_sof_slot", 32'(slot), 32'd1);

    // Missing SOF after a complete frame
    step(0, 1, 0, 8'h40);
    step(0, 1, 0, 8'h41);
    step(0, 1, 0, 8'h42);
    step(0, 1, 0, 8'h55);
    chk("missing_sof_locked", 32'(locked), 32'd0);

    // Gapped input and mid-frame reset
    step(0, 1, 1, 8'h01);
    step(0, 0, 0, 8'hEE);
    step(0, 1, 0, 8'h02);
    step(0, 0, 1, 8'hEE);
    step(0, 0, 0, 8'hEE);
    step(0, 1, 0, 8'h03);
    step(1, 1, 0, 8'h04);
    chk("midreset_data", ch_data, 32'h0);

    // Clean frame 01..04 (latched build publishes it on the slot-3 word)
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h02);
    step(0, 1, 0, 8'h03);
    step(0, 1, 0, 8'h04);
    chk("frame_0403", ch_data, 32'h04030201);

    // Randomised traffic, mostly well-formed with occasional faults
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (m_slot == 0);
      step(r, v, s, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
